move_pacer: RTL and testbench

MOVE_PACER -- requirements
Module: move_pacer

---
 rtl/move_pacer.sv | 153 +++++++++++++++
 tb/tb_move_pacer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/move_pacer.sv
// Multi-channel auto-repeat pacer: each held direction gives an immediate move strobe,
// then periodic strobes whose rate optionally ramps up through NUM_LVL speed levels.
module move_pacer #(
    parameter int NUM_DIR     = 4,
    parameter int BASE_PERIOD = 1111111,
    parameter int NUM_LVL     = 4,
    parameter int RAMP_MOVES  = 8,
    parameter int PAIR_CANCEL = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_DIR-1:0]     dir_req,
    input  logic                   mode,
    input  logic                   pause,
    output logic [NUM_DIR-1:0]     move_pulse,
    output logic [NUM_DIR*3-1:0]   speed_lvl,
    output logic [NUM_DIR-1:0]     active
);

    localparam int CNT_W  = (BASE_PERIOD > 1) ? $clog2(BASE_PERIOD) : 1;
    localparam int PER_W  = CNT_W + 1;
    localparam int NMOV_W = $clog2(RAMP_MOVES + 1);
    localparam logic [2:0]        LVL_MAX  = 3'(NUM_LVL - 1);
    localparam logic [NMOV_W-1:0] NMOV_END = NMOV_W'(RAMP_MOVES);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [PER_W-1:0] period_of(input logic [2:0] lvl);
        return PER_W'(32'(BASE_PERIOD) >> lvl);
    endfunction

    function automatic logic [2:0] lvl_step(input logic [2:0] lvl);
        return (lvl < LVL_MAX) ? lvl + 3'd1 : LVL_MAX;
    endfunction

    // Release flop: channels stay parked for one edge after reset rises.
    logic run_en_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_en_q <= 1'b0;
        end else begin
            run_en_q <= 1'b1;
        end
    end

    logic [NUM_DIR-1:0] eff;

    always_comb begin
        eff = dir_req;
        if (PAIR_CANCEL != 0) begin
            for (int k = 0; k < NUM_DIR / 2; k++) begin
                if (dir_req[2*k] && dir_req[2*k+1]) begin
                    eff[2*k]   = 1'b0;
                    eff[2*k+1] = 1'b0;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_DIR; i++) begin : g_ch
        state_t              state_q, state_d;
        logic [CNT_W-1:0]    cnt_q, cnt_d;
        logic [2:0]          lvl_q, lvl_d;
        logic [NMOV_W-1:0]   nmov_q, nmov_d;
        logic                pulse_q, pulse_d;
        logic [PER_W-1:0]    cnt_inc;
        logic [NMOV_W-1:0]   nmov_inc;
        logic                fire;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                lvl_q   <= '0;
                nmov_q  <= '0;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                lvl_q   <= lvl_d;
                nmov_q  <= nmov_d;
                pulse_q <= pulse_d;
            end
        end

        // ">=" rather than "==" so a shortened period never lets cnt run past it.
        assign cnt_inc  = {1'b0, cnt_q} + PER_W'(1);
        assign fire     = (cnt_inc >= period_of(lvl_q));
        assign nmov_inc = nmov_q + NMOV_W'(1);

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            lvl_d   = lvl_q;
            nmov_d  = nmov_q;
            pulse_d = 1'b0;
            if (!run_en_q) begin
                state_d = IDLE;
                cnt_d   = '0;
                lvl_d   = '0;
                nmov_d  = '0;
            end else if (!pause) begin
                case (state_q)
                    IDLE: begin
                        if (eff[i]) begin
                            pulse_d = 1'b1;
                            state_d = RUN;
                            cnt_d   = '0;
                            lvl_d   = '0;
                            nmov_d  = '0;
                        end
                    end
                    RUN: begin
                        if (!eff[i]) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            lvl_d   = '0;
                            nmov_d  = '0;
                        end else begin
                            if (fire) begin
                                pulse_d = 1'b1;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_inc[CNT_W-1:0];
                            end
                            if (!mode) begin
                                lvl_d  = '0;
                                nmov_d = '0;
                            end else if (fire) begin
                                if (nmov_inc == NMOV_END) begin
                                    lvl_d  = lvl_step(lvl_q);
                                    nmov_d = '0;
                                end else begin
                                    nmov_d = nmov_inc;
                                end
                            end
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        assign move_pulse[i]      = pulse_q;
        assign speed_lvl[3*i +: 3] = lvl_q;
        assign active[i]          = (state_q == RUN);
    end

endmodule

// File: tb/tb_move_pacer.sv
// Scoreboard bench for move_pacer: directed scenarios then random traffic, all
// predicted by an elapsed-time reference model and checked by a separate monitor.
module tb_move_pacer;

    localparam int ND = 4;
    localparam int BP = 16;
    localparam int NL = 4;
    localparam int RM = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [ND-1:0] dir_req = '0;
    logic          mode = 1'b0;
    logic          pause = 1'b0;
    logic [ND-1:0] move_pulse;
    logic [ND*3-1:0] speed_lvl;
    logic [ND-1:0] active;

    always #5 clk = ~clk;

    move_pacer #(
        .NUM_DIR    (ND),
        .BASE_PERIOD(BP),
        .NUM_LVL    (NL),
        .RAMP_MOVES (RM),
        .PAIR_CANCEL(1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .dir_req   (dir_req),
        .mode      (mode),
        .pause     (pause),
        .move_pulse(move_pulse),
        .speed_lvl (speed_lvl),
        .active    (active)
    );

    typedef struct {
        logic [ND-1:0]   pulse;
        logic [ND*3-1:0] spd;
        logic [ND-1:0]   act;
        bit              clr;
        int              chk;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: per channel, running flag, unpaused cycles since last
    // strobe, current level and strobes emitted at that level.
    bit m_en = 1'b0;
    bit m_run[ND];
    int m_since[ND];
    int m_lvl[ND];
    int m_at[ND];
    bit clr_next = 1'b0;
    int chk_next = 0;

    task automatic model_step(output exp_t e);
        bit eff;
        int per;
        e.pulse = '0;
        e.spd   = '0;
        e.act   = '0;
        e.clr   = 1'b0;
        e.chk   = 0;
        if (!reset) begin
            m_en = 1'b0;
            for (int i = 0; i < ND; i++) begin
                m_run[i] = 1'b0; m_since[i] = 0; m_lvl[i] = 0; m_at[i] = 0;
            end
        end else if (!m_en) begin
            m_en = 1'b1;
        end else if (!pause) begin
            for (int i = 0; i < ND; i++) begin
                eff = dir_req[i] && !dir_req[i ^ 1];
                if (!m_run[i]) begin
                    if (eff) begin
                        e.pulse[i] = 1'b1;
                        m_run[i] = 1'b1; m_since[i] = 0; m_lvl[i] = 0; m_at[i] = 0;
                    end
                end else if (!eff) begin
                    m_run[i] = 1'b0; m_since[i] = 0; m_lvl[i] = 0; m_at[i] = 0;
                end else begin
                    per = BP >> m_lvl[i];
                    m_since[i] = m_since[i] + 1;
                    if (m_since[i] >= per) begin
                        e.pulse[i] = 1'b1;
                        m_since[i] = 0;
                        if (mode) begin
                            m_at[i] = m_at[i] + 1;
                            if (m_at[i] == RM) begin
                                if (m_lvl[i] < NL - 1) m_lvl[i] = m_lvl[i] + 1;
                                m_at[i] = 0;
                            end
                        end
                    end
                    if (!mode) begin
                        m_lvl[i] = 0;
                        m_at[i]  = 0;
                    end
                end
            end
        end
        for (int i = 0; i < ND; i++) begin
            e.spd[3*i +: 3] = 3'(m_lvl[i]);
            e.act[i]        = m_run[i];
        end
    endtask

    task automatic cycle(input logic [ND-1:0] d, input logic md, input logic ps, input logic rs);
        exp_t e;
        @(negedge clk);
        dir_req = d;
        mode    = md;
        pause   = ps;
        reset   = rs;
        model_step(e);
        e.clr    = clr_next;
        e.chk    = chk_next;
        clr_next = 1'b0;
        chk_next = 0;
        sbq.push_back(e);
    endtask

    // Monitor: pops one expectation per clock and compares the DUT outputs.
    int plog[$];
    int gaps_fix[3]  = '{16, 16, 16};
    int gaps_ramp[9] = '{16, 16, 8, 8, 4, 4, 2, 2, 2};

    task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
        tests++;
        if (act_v !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act_v, exp_v, $time);
        end
    endtask

    task automatic gap_check(input int id);
        int n;
        int g;
        n = (id == 1) ? 3 : 9;
        chk("gap_count_ok", 32'(plog.size() >= n + 1), 32'd1);
        for (int k = 0; k < n; k++) begin
            if (k + 1 < plog.size()) begin
                g = (id == 1) ? gaps_fix[k] : gaps_ramp[k];
                chk($sformatf("gap%0d_%0d", id, k), 32'(plog[k+1] - plog[k]), 32'(g));
            end
        end
    endtask

    initial begin
        exp_t e;
        int cyc;
        logic [ND-1:0] prev;
        cyc  = 0;
        prev = '0;
        forever begin
            @(posedge clk);
            #3;
            cyc++;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                if (e.clr) plog.delete();
                chk("move_pulse", 32'(move_pulse), 32'(e.pulse));
                chk("speed_lvl", 32'(speed_lvl), 32'(e.spd));
                chk("active", 32'(active), 32'(e.act));
                chk("no_back_to_back", 32'(move_pulse & prev), 32'd0);
                if (move_pulse[0]) plog.push_back(cyc);
                if (e.chk != 0) gap_check(e.chk);
            end
            prev = move_pulse;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ND-1:0] d;
        logic md, ps, rs;
        #1 reset = 1'b0;
        repeat (3) cycle(4'b0000, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle(4'b0000, 1'b0, 1'b0, 1'b1);

        // fixed rate
        clr_next = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (k == 59) chk_next = 1;
            cycle(4'b0001, 1'b0, 1'b0, 1'b1);
        end
        repeat (2) cycle(4'b0000, 1'b0, 1'b0, 1'b1);

        // ramp
        clr_next = 1'b1;
        for (int k = 0; k < 70; k++) begin
            if (k == 69) chk_next = 2;
            cycle(4'b0001, 1'b1, 1'b0, 1'b1);
        end
        repeat (2) cycle(4'b0000, 1'b0, 1'b0, 1'b1);

        // opposing pair cancels, then one side released
        repeat (10) cycle(4'b0011, 1'b0, 1'b0, 1'b1);
        repeat (5)  cycle(4'b0001, 1'b0, 1'b0, 1'b1);
        repeat (2)  cycle(4'b0000, 1'b0, 1'b0, 1'b1);

        // pause at cnt=5
        repeat (6)  cycle(4'b0001, 1'b0, 1'b0, 1'b1);
        repeat (20) cycle(4'b0001, 1'b0, 1'b1, 1'b1);
        repeat (15) cycle(4'b0001, 1'b0, 1'b0, 1'b1);
        repeat (2)  cycle(4'b0000, 1'b0, 1'b0, 1'b1);

        // reset mid-run at cnt=10, request held through release
        repeat (11) cycle(4'b0101, 1'b1, 1'b0, 1'b1);
        repeat (3)  cycle(4'b0101, 1'b1, 1'b0, 1'b0);
        repeat (20) cycle(4'b0101, 1'b1, 1'b0, 1'b1);
        repeat (2)  cycle(4'b0000, 1'b0, 1'b0, 1'b1);

        // one-cycle release at level 2
        repeat (52) cycle(4'b0001, 1'b1, 1'b0, 1'b1);
        cycle(4'b0000, 1'b1, 1'b0, 1'b1);
        repeat (6)  cycle(4'b0001, 1'b1, 1'b0, 1'b1);

        // random traffic
        d = 4'b0000; md = 1'b1; ps = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < ND; b++) begin
                if ($urandom_range(0, 24) == 0) d[b] = ~d[b];
            end
            if ($urandom_range(0, 39) == 0) ps = ~ps;
            if ($urandom_range(0, 99) == 0) md = ~md;
            rs = ($urandom_range(0, 799) != 0);
            cycle(d, md, ps, rs);
        end

        @(posedge clk);
        #6;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
